// File: rtl/photo_booth_pkg.sv
// photo_booth_pkg
//   Shared types and constants for the photo-booth display sequencer.
//   - state_t : sequencer states
//   - GLYPH_* : glyph codes understood by the per-digit 7-segment decoders
//   - MODE_*  : 2-bit mode codes arriving on the GPIO link
package photo_booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TITLE0,
    TITLE1,
    COUNT,
    SAY,
    CHEESE,
    POST,
    FILTER
  } state_t;

  // Codes 1..5 are the digit glyphs themselves.
  localparam int GLYPH_BLANK = 0;
  localparam int GLYPH_C     = 6;
  localparam int GLYPH_H     = 7;
  localparam int GLYPH_E     = 8;
  localparam int GLYPH_S     = 9;
  localparam int GLYPH_F     = 10;
  localparam int GLYPH_I     = 11;
  localparam int GLYPH_L     = 12;
  localparam int GLYPH_T     = 13;
  localparam int GLYPH_R     = 14;
  localparam int GLYPH_A     = 15;
  localparam int GLYPH_Y     = 16;
  localparam int GLYPH_O     = 17;
  localparam int GLYPH_N     = 18;
  localparam int GLYPH_P     = 19;

  localparam logic [1:0] MODE_TITLE  = 2'b00;
  localparam logic [1:0] MODE_PHOTO  = 2'b01;
  localparam logic [1:0] MODE_FILTER = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;  // behaves as MODE_TITLE

endpackage

// File: rtl/photo_booth_if.sv
// photo_booth_if
//   Groups the sequencer's GPIO-side inputs and display-side outputs.
//   mode[1:0], retake : driven by the master (link side)
//   shutter, busy     : status back to the master
//   hex0..hex5        : glyph codes, hex0 is the rightmost digit
//   master modport: link/test side; slave modport: the sequencer.
interface photo_booth_if #(
  parameter int GLYPH_W = 5
);
  logic [1:0]         mode;
  logic               retake;
  logic               shutter;
  logic               busy;
  logic [GLYPH_W-1:0] hex0;
  logic [GLYPH_W-1:0] hex1;
  logic [GLYPH_W-1:0] hex2;
  logic [GLYPH_W-1:0] hex3;
  logic [GLYPH_W-1:0] hex4;
  logic [GLYPH_W-1:0] hex5;

  modport master (
    output mode, retake,
    input  shutter, busy, hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  mode, retake,
    output shutter, busy, hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/booth_tick_div.sv
// booth_tick_div
//   Free-running divider producing one tick every DIV clocks.
//   clk_50 : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous restart of the count at 0
//   tick   : high for the one cycle in which the count sits at DIV-1
module booth_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/photo_booth_sequencer.sv
// photo_booth_sequencer
//   Mode-driven photo-booth display sequencer: title animation, countdown,
//   SAY / CHEESE, one-cycle shutter pulse, post-photo retake, filter screen.
//   clk_50 : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : photo_booth_if.slave (mode, retake in; shutter, busy, hex0..hex5 out)
//   Optional build macro PHOTO_BOOTH_SYNC_EN: mode/retake pass through a
//   2-flop synchroniser first (responses delayed by two cycles).
module photo_booth_sequencer
  import photo_booth_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int COUNT_START = 5,
  parameter int TITLE_TICKS = 1,
  parameter int GLYPH_W     = 5
) (
  input logic          clk_50,
  input logic          rst_n,
  photo_booth_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = $clog2(TITLE_TICKS + 1);
  localparam logic [TW-1:0] TITLE_LAST = TW'(TITLE_TICKS - 1);

  logic [1:0] m;
  logic       rt;

`ifdef PHOTO_BOOTH_SYNC_EN
  logic [1:0] mode_meta_reg, mode_sync_reg;
  logic       retake_meta_reg, retake_sync_reg;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta_reg   <= '0;
      mode_sync_reg   <= '0;
      retake_meta_reg <= 1'b0;
      retake_sync_reg <= 1'b0;
    end else begin
      mode_meta_reg   <= bus.mode;
      mode_sync_reg   <= mode_meta_reg;
      retake_meta_reg <= bus.retake;
      retake_sync_reg <= retake_meta_reg;
    end
  end

  assign m  = mode_sync_reg;
  assign rt = retake_sync_reg;
`else
  assign m  = bus.mode;
  assign rt = bus.retake;
`endif

  state_t             state_reg, state_next;
  logic [2:0]         count_reg, count_next;
  logic [TW-1:0]      title_cnt_reg, title_cnt_next;
  logic               busy_reg, busy_next;
  logic               shutter_reg, shutter_next;
  logic [GLYPH_W-1:0] hex_reg  [6];
  logic [GLYPH_W-1:0] hex_next [6];
  logic               div_clear;
  logic               tick;

  booth_tick_div #(.DIV(DIV)) u_tick_div (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .clear  (div_clear),
    .tick   (tick)
  );

  function automatic logic [GLYPH_W-1:0] gl(input int code);
    return GLYPH_W'(code);
  endfunction

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      title_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      shutter_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      title_cnt_reg <= title_cnt_next;
      busy_reg      <= busy_next;
      shutter_reg   <= shutter_next;
    end
  end

  // Mode is decoded first so a mode change always pre-empts a tick.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    title_cnt_next = title_cnt_reg;
    div_clear      = 1'b0;
    case (m)
      MODE_FILTER: state_next = FILTER;
      MODE_PHOTO: begin
        case (state_reg)
          IDLE, TITLE0, TITLE1, FILTER: begin
            state_next = COUNT;
            count_next = 3'(COUNT_START);
            div_clear  = 1'b1;
          end
          COUNT: begin
            if (tick) begin
              if (count_reg > 3'd1) count_next = count_reg - 3'd1;
              else                  state_next = SAY;
            end
          end
          SAY:    if (tick) state_next = CHEESE;
          CHEESE: if (tick) state_next = POST;
          POST: begin
            if (rt) begin
              state_next = COUNT;
              count_next = 3'(COUNT_START);
              div_clear  = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
      default: begin  // MODE_TITLE and MODE_RSVD
        if (state_reg == TITLE0 || state_reg == TITLE1) begin
          if (tick) begin
            if (title_cnt_reg == TITLE_LAST) begin
              title_cnt_next = '0;
              state_next     = (state_reg == TITLE0) ? TITLE1 : TITLE0;
            end else begin
              title_cnt_next = title_cnt_reg + 1'b1;
            end
          end
        end else begin
          state_next     = TITLE0;
          title_cnt_next = '0;
        end
      end
    endcase
  end

  // Display and status come from the next state so they move with state_reg.
  always_comb begin
    for (int i = 0; i < 6; i++) hex_next[i] = gl(GLYPH_BLANK);
    busy_next    = (state_next == COUNT) || (state_next == SAY) || (state_next == CHEESE);
    shutter_next = (state_reg == CHEESE) && (state_next == POST);
    case (state_next)
      TITLE0: begin
        hex_next[3] = gl(GLYPH_O);
        hex_next[2] = gl(GLYPH_H);
      end
      TITLE1: begin
        hex_next[4] = gl(GLYPH_S);
        hex_next[3] = gl(GLYPH_N);
        hex_next[2] = gl(GLYPH_A);
        hex_next[1] = gl(GLYPH_P);
      end
      COUNT: hex_next[0] = GLYPH_W'(count_next);
      SAY: begin
        hex_next[2] = gl(GLYPH_S);
        hex_next[1] = gl(GLYPH_A);
        hex_next[0] = gl(GLYPH_Y);
      end
      CHEESE: begin
        hex_next[5] = gl(GLYPH_C);
        hex_next[4] = gl(GLYPH_H);
        hex_next[3] = gl(GLYPH_E);
        hex_next[2] = gl(GLYPH_E);
        hex_next[1] = gl(GLYPH_S);
        hex_next[0] = gl(GLYPH_E);
      end
      FILTER: begin
        hex_next[5] = gl(GLYPH_F);
        hex_next[4] = gl(GLYPH_I);
        hex_next[3] = gl(GLYPH_L);
        hex_next[2] = gl(GLYPH_T);
        hex_next[1] = gl(GLYPH_E);
        hex_next[0] = gl(GLYPH_R);
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_hex
    always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) hex_reg[gi] <= '0;
      else        hex_reg[gi] <= hex_next[gi];
    end
  end

  assign bus.hex0    = hex_reg[0];
  assign bus.hex1    = hex_reg[1];
  assign bus.hex2    = hex_reg[2];
  assign bus.hex3    = hex_reg[3];
  assign bus.hex4    = hex_reg[4];
  assign bus.hex5    = hex_reg[5];
  assign bus.busy    = busy_reg;
  assign bus.shutter = shutter_reg;
endmodule

// File: tb/tb_photo_booth_sequencer.sv
// tb_photo_booth_sequencer
//   Directed bench for photo_booth_sequencer with DIV=4 (CLK_HZ=8,
//   TICK_HZ=2), COUNT_START=5, TITLE_TICKS=1, default (unsynchronised) build.
module tb_photo_booth_sequencer;
  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_50 = ~clk_50;

  photo_booth_if #(.GLYPH_W(5)) bus ();

  photo_booth_sequencer #(
    .CLK_HZ      (8),
    .TICK_HZ     (2),
    .COUNT_START (5),
    .TITLE_TICKS (1),
    .GLYPH_W     (5)
  ) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  function automatic logic [31:0] pat(input int h5, h4, h3, h2, h1, h0);
    return {2'b00, 5'(h5), 5'(h4), 5'(h3), 5'(h2), 5'(h1), 5'(h0)};
  endfunction

  function automatic logic [31:0] hexv();
    return {2'b00, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  logic [31:0] p_blank, p_oh, p_snap, p_say, p_cheese, p_filter;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] h, input logic b, input logic s);
    chk({tag, "_hex"}, hexv(), h);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
    chk({tag, "_shut"}, 32'(bus.shutter), 32'(s));
  endtask

  initial begin
    p_blank  = pat(0, 0, 0, 0, 0, 0);
    p_oh     = pat(0, 0, 17, 7, 0, 0);
    p_snap   = pat(0, 9, 18, 15, 19, 0);
    p_say    = pat(0, 0, 0, 9, 15, 16);
    p_cheese = pat(6, 7, 8, 8, 9, 8);
    p_filter = pat(10, 11, 12, 13, 8, 14);

    bus.mode   = 2'b00;
    bus.retake = 1'b0;
    step(3);
    chk_all("reset", p_blank, 1'b0, 1'b0);

    // Title animation: OH on edge 1, SNAP on edge 4 (divider free-runs from 0).
    @(negedge clk_50);
    rst_n = 1'b1;
    step(1); chk("title_e1", hexv(), p_oh);
    step(2); chk("title_e3", hexv(), p_oh);
    step(1); chk("title_e4", hexv(), p_snap);
    step(3); chk("title_e7", hexv(), p_snap);
    step(1); chk("title_e8", hexv(), p_oh);

    // Full photo run: 5 digits, SAY, CHEESE, each 4 cycles, then POST.
    bus.mode = 2'b01;
    step(1);
    for (int i = 0; i < 28; i++) begin
      logic [31:0] e;
      if (i < 20)      e = pat(0, 0, 0, 0, 0, 5 - i / 4);
      else if (i < 24) e = p_say;
      else             e = p_cheese;
      chk_all($sformatf("run_c%0d", i), e, 1'b1, 1'b0);
      step(1);
    end
    chk_all("post_e28", p_blank, 1'b0, 1'b1);
    step(1);
    chk_all("post_e29", p_blank, 1'b0, 1'b0);

    // Retake: one-cycle retake restarts at 5 with a full first digit.
    bus.retake = 1'b1;
    step(1);
    bus.retake = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("retake_c%0d", i), pat(0, 0, 0, 0, 0, 5), 1'b1, 1'b0);
      step(1);
    end
    chk("retake_d4", hexv(), pat(0, 0, 0, 0, 0, 4));

    // Abort to FILTER while digit 3 is showing.
    step(4);
    chk("abort_d3", hexv(), pat(0, 0, 0, 0, 0, 3));
    bus.mode = 2'b10;
    step(1);
    chk_all("filter_e1", p_filter, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("filter_noshut%0d", i), 32'(bus.shutter), 32'd0);
    end

    // From FILTER into a fresh run; reset mid-CHEESE.
    bus.mode = 2'b01;
    step(1);
    chk_all("f2c_e0", pat(0, 0, 0, 0, 0, 5), 1'b1, 1'b0);
    step(24);
    chk_all("f2c_e24", p_cheese, 1'b1, 1'b0);
    step(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", p_blank, 1'b0, 1'b0);
    step(2);
    chk_all("rst_hold", p_blank, 1'b0, 1'b0);
    @(negedge clk_50);
    rst_n = 1'b1;
    step(1);
    chk_all("rst_restart", pat(0, 0, 0, 0, 0, 5), 1'b1, 1'b0);
    step(4);
    chk("rst_restart_d4", hexv(), pat(0, 0, 0, 0, 0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
